// File: rtl/unstripe_lane_scheduler_pkg.sv
// Shared definitions for the 2-lane byte striping/un-striping path.
package unstripe_lane_scheduler_pkg;

    // Default byte width shared by both directions of the path.
    localparam int ULS_DATA_W = 8;

    // Un-striper scheduler states; the encoding is fixed for the striping side.
    localparam logic [1:0] ST_WAIT_L0 = 2'd0;
    localparam logic [1:0] ST_WAIT_L1 = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage

// File: rtl/unstripe_lane_scheduler_if.sv
// Lane inputs, output byte stream and status flags of the un-striping scheduler.
interface unstripe_lane_scheduler_if
    import unstripe_lane_scheduler_pkg::*;
#(
    parameter int DATA_W = ULS_DATA_W,
    parameter int ADDR_W = 2
);
    logic              push_0;
    logic [DATA_W-1:0] lane_0;
    logic              push_1;
    logic [DATA_W-1:0] lane_1;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [ADDR_W:0]   level_0;
    logic [ADDR_W:0]   level_1;
    logic              overflow;
    logic              skew_err;

    // Source of lane bytes and sink of the merged stream.
    modport master (
        output push_0, lane_0, push_1, lane_1, out_ready,
        input  data_out, valid_out, level_0, level_1, overflow, skew_err
    );

    // The scheduler itself.
    modport slave (
        input  push_0, lane_0, push_1, lane_1, out_ready,
        output data_out, valid_out, level_0, level_1, overflow, skew_err
    );
endinterface

// File: rtl/unstripe_lane_scheduler_lane_fifo.sv
// Per-lane synchronous FIFO with flush, occupancy and dropped-push flag.
module lane_fifo
    import unstripe_lane_scheduler_pkg::*;
#(
    parameter int DATA_W = ULS_DATA_W,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
)(
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_level,
    output logic              o_drop
);
    // Storage is read combinationally so a byte written at one edge can be popped at the next.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   w_level;
    logic              w_full;
    logic              w_empty;
    logic              w_do_pop;
    logic              w_do_push;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_level == (ADDR_W+1)'(DEPTH));
    assign w_empty   = (w_level == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A same-edge pop frees the slot, so a full FIFO still accepts the push.
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

    assign o_dout  = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = w_level;
    assign o_drop  = i_push && w_full && !w_do_pop;

    // Pointer update: reset and flush both empty the FIFO.
    always_ff @(posedge clk_2f) begin
        if (!reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Data storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk_2f) begin
        if (w_do_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_din;
    end

endmodule

// File: rtl/unstripe_lane_scheduler.sv
// Receive-side un-striper: merges two buffered byte lanes in strict lane0/lane1 order.
module unstripe_lane_scheduler
    import unstripe_lane_scheduler_pkg::*;
#(
    parameter int DATA_W     = ULS_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2,
    parameter int SKEW_MAX   = 3
)(
    input  logic                      clk_2f,
    input  logic                      reset,
    unstripe_lane_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(SKEW_MAX + 1);
    localparam logic [CNT_W-1:0] SKEW_LAST = CNT_W'(SKEW_MAX - 1);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_overflow;
    logic              r_skew_err;

    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  w_wait_cnt_next;
    logic [DATA_W-1:0] w_data_next;
    logic              w_valid_next;
    logic              w_load;
    logic              w_flush;

    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_empty;
    logic [1:0]        w_full;
    logic [1:0]        w_drop;
    logic [DATA_W-1:0] w_din   [2];
    logic [DATA_W-1:0] w_dout  [2];
    logic [ADDR_W:0]   w_level [2];

    assign w_push[0] = bus.push_0;
    assign w_push[1] = bus.push_1;
    assign w_din[0]  = bus.lane_0;
    assign w_din[1]  = bus.lane_1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            lane_fifo #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .DEPTH  (FIFO_DEPTH)
            ) u_fifo (
                .clk_2f  (clk_2f),
                .reset   (reset),
                .i_push  (w_push[gi]),
                .i_din   (w_din[gi]),
                .i_pop   (w_pop[gi]),
                .i_flush (w_flush),
                .o_dout  (w_dout[gi]),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi]),
                .o_level (w_level[gi]),
                .o_drop  (w_drop[gi])
            );
        end
    endgenerate

    // Output register may take a new byte when empty or when downstream drains it.
    assign w_load = !r_valid_out || bus.out_ready;

    // Lane scheduling: alternate lanes, count stalled lane1 slots, flush on excessive skew.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_data_next     = r_data_out;
        w_valid_next    = r_valid_out;
        w_pop           = 2'b00;
        w_flush         = 1'b0;
        case (r_state)
            ST_WAIT_L0: begin
                if (w_load) begin
                    if (!w_empty[0]) begin
                        w_pop[0]        = 1'b1;
                        w_data_next     = w_dout[0];
                        w_valid_next    = 1'b1;
                        w_wait_cnt_next = '0;
                        w_state_next    = ST_WAIT_L1;
                    end else begin
                        w_valid_next = 1'b0;
                    end
                end
            end
            ST_WAIT_L1: begin
                // Backpressure cycles (load low) never count toward the skew limit.
                if (w_load) begin
                    if (!w_empty[1]) begin
                        w_pop[1]        = 1'b1;
                        w_data_next     = w_dout[1];
                        w_valid_next    = 1'b1;
                        w_wait_cnt_next = '0;
                        w_state_next    = ST_WAIT_L0;
                    end else begin
                        w_valid_next = 1'b0;
                        if (r_wait_cnt == SKEW_LAST) begin
                            w_wait_cnt_next = '0;
                            w_state_next    = ST_FLUSH;
                        end else begin
                            w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                        end
                    end
                end
            end
            ST_FLUSH: begin
                // Pending output byte is still delivered; only the lane buffers are discarded.
                w_flush         = 1'b1;
                w_wait_cnt_next = '0;
                w_state_next    = ST_WAIT_L0;
                if (w_load) w_valid_next = 1'b0;
            end
            default: begin
                w_wait_cnt_next = '0;
                w_state_next    = ST_WAIT_L0;
            end
        endcase
    end

    // State, output register and status flag update.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            r_state     <= ST_WAIT_L0;
            r_wait_cnt  <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_overflow  <= 1'b0;
            r_skew_err  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_data_out  <= w_data_next;
            r_valid_out <= w_valid_next;
            r_overflow  <= r_overflow | (|w_drop);
            r_skew_err  <= (r_state == ST_FLUSH);
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.level_0   = w_level[0];
    assign bus.level_1   = w_level[1];
    assign bus.overflow  = r_overflow;
    assign bus.skew_err  = r_skew_err;

endmodule

// File: tb/tb_unstripe_lane_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_unstripe_lane_scheduler;
    localparam int DEPTH    = 4;
    localparam int SKEW_MAX = 3;

    logic clk_2f;
    logic reset;

    unstripe_lane_scheduler_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    unstripe_lane_scheduler #(
        .DATA_W(8), .FIFO_DEPTH(DEPTH), .ADDR_W(2), .SKEW_MAX(SKEW_MAX)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: lane queues, which lane owes the next byte, missed lane1 slots.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;
    logic       m_ovf   = 1'b0;
    logic       m_skew  = 1'b0;
    logic       m_flush_due = 1'b0;
    int         m_next_lane = 0;
    int         m_missed    = 0;

    logic [7:0] got[$];
    bit         saw_skew;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit load;
        if (!reset) begin
            q0.delete(); q1.delete();
            m_valid = 0; m_data = 0; m_ovf = 0; m_skew = 0;
            m_flush_due = 0; m_next_lane = 0; m_missed = 0;
            return;
        end
        load = !m_valid || bus.out_ready;
        if (m_flush_due) begin
            if (bus.push_0 && q0.size() == DEPTH) m_ovf = 1;
            if (bus.push_1 && q1.size() == DEPTH) m_ovf = 1;
            q0.delete(); q1.delete();
            m_skew = 1; m_flush_due = 0; m_next_lane = 0; m_missed = 0;
            if (load) m_valid = 0;
        end else begin
            m_skew = 0;
            if (load) begin
                if (m_next_lane == 0 && q0.size() > 0) begin
                    m_data = q0.pop_front(); m_valid = 1; m_next_lane = 1; m_missed = 0;
                end else if (m_next_lane == 1 && q1.size() > 0) begin
                    m_data = q1.pop_front(); m_valid = 1; m_next_lane = 0; m_missed = 0;
                end else begin
                    m_valid = 0;
                    if (m_next_lane == 1) begin
                        m_missed++;
                        if (m_missed == SKEW_MAX) begin
                            m_flush_due = 1;
                            m_missed = 0;
                        end
                    end
                end
            end
            if (bus.push_0) begin
                if (q0.size() < DEPTH) q0.push_back(bus.lane_0); else m_ovf = 1;
            end
            if (bus.push_1) begin
                if (q1.size() < DEPTH) q1.push_back(bus.lane_1); else m_ovf = 1;
            end
        end
    endtask

    // One clock: log accepted byte, advance model, compare all outputs after the edge.
    task automatic step();
        if (bus.valid_out && bus.out_ready) begin
            got.push_back(bus.data_out);
            $display("txn t=%0t byte=0x%02h lvl0=%0d lvl1=%0d", $time, bus.data_out, bus.level_0, bus.level_1);
        end
        @(posedge clk_2f);
        model_edge();
        #1;
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        if (m_valid) chk("data_out", 32'(bus.data_out), 32'(m_data));
        chk("level_0", 32'(bus.level_0), 32'(q0.size()));
        chk("level_1", 32'(bus.level_1), 32'(q1.size()));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("skew_err", 32'(bus.skew_err), 32'(m_skew));
        if (bus.skew_err) saw_skew = 1;
    endtask

    task automatic drive(input logic p0, input logic [7:0] d0, input logic p1, input logic [7:0] d1);
        bus.push_0 = p0; bus.lane_0 = d0;
        bus.push_1 = p1; bus.lane_1 = d1;
    endtask

    task automatic idle(input int n);
        drive(0, 8'h00, 0, 8'h00);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_stream(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            chk(tag, 32'(got[i]), 32'(exp[i]));
    endtask

    logic [7:0] exp_q[$];

    initial begin
        reset = 1'b0;
        bus.out_ready = 1'b1;
        drive(1, 8'h11, 1, 8'h22);

        // 1: reset held with pushes active
        step(); step();
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_level_0", 32'(bus.level_0), 32'd0);
        chk("rst_level_1", 32'(bus.level_1), 32'd0);
        reset = 1'b1;
        idle(2);

        // 2: interleaved pushes, one per edge
        got.delete(); saw_skew = 0;
        drive(1, 8'hA1, 0, 8'h00); step();
        drive(0, 8'h00, 1, 8'hB1); step();
        drive(1, 8'hA2, 0, 8'h00); step();
        drive(0, 8'h00, 1, 8'hB2); step();
        idle(6);
        exp_q = '{8'hA1, 8'hB1, 8'hA2, 8'hB2};
        check_stream("s2_order", exp_q);
        chk("s2_no_skew", 32'(saw_skew), 32'd0);

        // 3: lane1 lags lane0 by two cycles
        got.delete(); saw_skew = 0;
        drive(1, 8'hA1, 0, 8'h00); step();
        drive(1, 8'hA2, 0, 8'h00); step();
        drive(0, 8'h00, 1, 8'hB1); step();
        drive(0, 8'h00, 1, 8'hB2); step();
        idle(6);
        check_stream("s3_order", exp_q);
        chk("s3_no_skew", 32'(saw_skew), 32'd0);

        // 4: lane1 never arrives -> skew flush, then recovery
        got.delete(); saw_skew = 0;
        drive(1, 8'hA1, 0, 8'h00); step();
        idle(8);
        chk("s4_skew_seen", 32'(saw_skew), 32'd1);
        chk("s4_level_0", 32'(bus.level_0), 32'd0);
        chk("s4_level_1", 32'(bus.level_1), 32'd0);
        drive(1, 8'h5A, 0, 8'h00); step();
        idle(2);
        exp_q = '{8'hA1, 8'h5A};
        check_stream("s4_order", exp_q);
        idle(8);

        // 5: downstream stall while both lanes push five bytes
        got.delete(); saw_skew = 0;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            drive(1, 8'(8'hA0 + i), 1, 8'(8'hB0 + i));
            step();
        end
        idle(3);
        chk("s5_hold_data", 32'(bus.data_out), 32'hA1);
        chk("s5_level_0", 32'(bus.level_0), 32'd4);
        chk("s5_level_1", 32'(bus.level_1), 32'd4);
        chk("s5_overflow", 32'(bus.overflow), 32'd1);
        bus.out_ready = 1'b1;
        idle(16);
        exp_q = '{8'hA1, 8'hB1, 8'hA2, 8'hB2, 8'hA3, 8'hB3, 8'hA4, 8'hB4, 8'hA5};
        check_stream("s5_order", exp_q);

        // 6: reset mid-burst, then lane1 byte arrives before lane0 byte
        drive(1, 8'hE1, 1, 8'hF1); step();
        drive(1, 8'hE2, 1, 8'hF2); step();
        reset = 1'b0; step();
        reset = 1'b1;
        got.delete();
        chk("s6_overflow_clr", 32'(bus.overflow), 32'd0);
        drive(0, 8'h00, 1, 8'hC1); step();
        drive(1, 8'hD1, 0, 8'h00); step();
        idle(6);
        exp_q = '{8'hD1, 8'hC1};
        check_stream("s6_order", exp_q);

        // Randomized traffic with varying lane rates, backpressure and occasional reset
        for (int blk = 0; blk < 6; blk++) begin
            int p0, p1, pr;
            p0 = 30 + 30 * int'($urandom_range(0, 2));
            p1 = 30 + 30 * int'($urandom_range(0, 2));
            pr = (blk % 3 == 0) ? 100 : 40 + 25 * int'($urandom_range(0, 2));
            for (int c = 0; c < 400; c++) begin
                drive(($urandom % 100) < p0, 8'($urandom), ($urandom % 100) < p1, 8'($urandom));
                bus.out_ready = (($urandom % 100) < pr);
                reset = (($urandom % 300) != 0);
                step();
            end
        end
        reset = 1'b1;
        bus.out_ready = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
